// File: rtl/tcb_img_pkg.sv
// rtl/tcb_img_pkg.sv - shared frame geometry for the tcb classifier path
package tcb_img_pkg;
  localparam int PIX_W = 8;
  localparam int N_PIX = 121;
  localparam int IMG_W = PIX_W * N_PIX;
  localparam int CNT_W = $clog2(N_PIX);
endpackage

// File: rtl/tcb_frame_buf.sv
// rtl/tcb_frame_buf.sv - one frame register with a byte-indexed write port
module tcb_frame_buf
  import tcb_img_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [PIX_W-1:0] din,
  output logic [IMG_W-1:0] dout
);

  logic [IMG_W-1:0] data;

  // Pixel 0 lands in the most significant byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
    end else if (we) begin
      for (int k = 0; k < N_PIX; k++) begin
        if (idx == CNT_W'(k)) data[IMG_W-1-PIX_W*k -: PIX_W] <= din;
      end
    end
  end

  assign dout = data;

endmodule

// File: rtl/tcb_img_deserializer.sv
// rtl/tcb_img_deserializer.sv - serial pixel stream to ping-pong 11x11 frames
module tcb_img_deserializer
  import tcb_img_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [IMG_W-1:0] img_source,
  output logic             valid_top,
  input  logic             ready_top,
  output logic [7:0]       drop_cnt
);

  logic             wr;
  logic             rd;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             resync;
  logic             complete;
  logic             rel_top;
  logic [IMG_W-1:0] dout0;
  logic [IMG_W-1:0] dout1;

  assign pix_ready = !full[wr];
  assign accept    = pix_valid && pix_ready;
  // A start-of-frame mid-frame restarts the fill at pixel 0
  assign resync    = accept && pix_sof && (cnt != '0);
  assign idx       = resync ? '0 : cnt;
  assign complete  = accept && (idx == CNT_W'(N_PIX - 1));
  assign valid_top = full[rd];
  assign rel_top   = valid_top && ready_top;

  tcb_frame_buf u_buf0 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept && !wr),
    .idx  (idx),
    .din  (pix_in),
    .dout (dout0)
  );

  tcb_frame_buf u_buf1 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept && wr),
    .idx  (idx),
    .din  (pix_in),
    .dout (dout1)
  );

  assign img_source = rd ? dout1 : dout0;

  // Completion requires full[wr]=0 and release requires full[rd]=1, so both hit different buffers
  always_comb begin
    full_nxt = full;
    if (rel_top)  full_nxt[rd] = 1'b0;
    if (complete) full_nxt[wr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr       <= 1'b0;
      rd       <= 1'b0;
      full     <= 2'b00;
      cnt      <= '0;
      drop_cnt <= 8'd0;
    end else begin
      full <= full_nxt;
      if (complete) wr <= ~wr;
      if (rel_top)  rd <= ~rd;
      if (accept)   cnt <= complete ? '0 : idx + 1'b1;
      if (resync && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tcb_img_deserializer.sv
// tb/tb_tcb_img_deserializer.sv - scoreboard bench for tcb_img_deserializer
module tb_tcb_img_deserializer;
  import tcb_img_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_sof = 1'b0;
  logic             pix_ready;
  logic [IMG_W-1:0] img_source;
  logic             valid_top;
  logic             ready_top = 1'b0;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;
  int handshakes = 0;
  int stalls = 0;

  logic [IMG_W-1:0] exp_q[$];
  logic [IMG_W-1:0] fr_aa;
  logic [IMG_W-1:0] fr_55;

  always #5 clk = ~clk;

  tcb_img_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .img_source (img_source),
    .valid_top  (valid_top),
    .ready_top  (ready_top),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
    int bad;
    bad = -1;
    for (int k = N_PIX - 1; k >= 0; k--)
      if (act[IMG_W-1-PIX_W*k -: PIX_W] !== exp[IMG_W-1-PIX_W*k -: PIX_W]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s pixel %0d act=%02h exp=%02h", name, bad,
               act[IMG_W-1-PIX_W*bad -: PIX_W], exp[IMG_W-1-PIX_W*bad -: PIX_W]);
    end
  endtask

  // Present one beat and hold it until accepted
  task automatic send_pix(input logic [7:0] v, input logic sof);
    int n;
    pix_in = v;
    pix_valid = 1'b1;
    pix_sof = sof;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 1000) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL pix_ready_timeout act=0 exp=1");
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int p, input int k);
    case (mode)
      0:       pix_val = 8'(k + 1);
      1:       pix_val = 8'(p);
      default: pix_val = 8'(p * 37 + k * 3);
    endcase
  endfunction

  task automatic send_frame(input int mode, input int p, input logic sof_first, input logic push);
    logic [IMG_W-1:0] fr;
    logic [7:0] v;
    fr = '0;
    for (int k = 0; k < N_PIX; k++) begin
      v = pix_val(mode, p, k);
      fr[IMG_W-1-PIX_W*k -: PIX_W] = v;
      send_pix(v, sof_first && (k == 0));
    end
    if (push) exp_q.push_back(fr);
  endtask

  // Monitor: pops the scoreboard on every handshake, and checks hold stability under backpressure
  logic             hold_q = 1'b0;
  logic [IMG_W-1:0] img_q;
  logic [IMG_W-1:0] exp_fr;
  always @(negedge clk) begin
    if (!rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 32'(valid_top), 32'd1);
        chk_img("hold_img", img_source, img_q);
      end
      if (valid_top && ready_top) begin
        handshakes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame act=1 exp=0");
        end else begin
          exp_fr = exp_q.pop_front();
          chk_img("frame_data", img_source, exp_fr);
        end
      end
      hold_q = valid_top && !ready_top;
      img_q = img_source;
    end
  end

  int hs0;
  int st0;

  initial begin
    for (int k = 0; k < N_PIX; k++) begin
      fr_aa[IMG_W-1-PIX_W*k -: PIX_W] = 8'hAA;
      fr_55[IMG_W-1-PIX_W*k -: PIX_W] = 8'h55;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_valid_top", 32'(valid_top), 32'd0);
    chk_img("rst_img", img_source, '0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single frame, pixel k = k+1
    ready_top = 1'b1;
    send_frame(0, 0, 1'b1, 1'b1);
    chk("single_valid", 32'(valid_top), 32'd1);
    chk("single_msb", 32'(img_source[967:960]), 32'h01);
    chk("single_lsb", 32'(img_source[7:0]), 32'h79);
    @(posedge clk);
    #1;
    chk("single_valid_drop", 32'(valid_top), 32'd0);
    chk("single_drop_cnt", 32'(drop_cnt), 32'd0);

    // Backpressure: two frames absorbed, then stall
    ready_top = 1'b0;
    send_frame(1, 8'hAA, 1'b0, 1'b1);
    send_frame(1, 8'h55, 1'b0, 1'b1);
    chk("bp_pix_ready_low", 32'(pix_ready), 32'd0);
    chk("bp_valid", 32'(valid_top), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_img("bp_img_aa", img_source, fr_aa);
    chk("bp_still_stalled", 32'(pix_ready), 32'd0);
    ready_top = 1'b1;
    @(posedge clk);
    #1;
    ready_top = 1'b0;
    chk_img("bp_img_55", img_source, fr_55);
    chk("bp_pix_ready_back", 32'(pix_ready), 32'd1);
    chk("bp_valid_55", 32'(valid_top), 32'd1);
    ready_top = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drained", 32'(valid_top), 32'd0);

    // Resync: 50 stale pixels, then a fresh frame with sof
    for (int k = 0; k < 50; k++) send_pix(8'(8'hE0 ^ k), k == 0);
    send_frame(2, 5, 1'b1, 1'b1);
    chk("resync_drop_cnt", 32'(drop_cnt), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Streaming: 10 frames back to back
    hs0 = handshakes;
    st0 = stalls;
    for (int f = 0; f < 10; f++) send_frame(2, 10 + f, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_handshakes", 32'(handshakes - hs0), 32'd10);
    chk("stream_no_stall", 32'(stalls - st0), 32'd0);

    // Mid-frame reset with one full buffer pending
    ready_top = 1'b0;
    send_frame(1, 8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 80; k++) send_pix(8'h44, 1'b0);
    chk("pre_reset_valid", 32'(valid_top), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mrst_valid", 32'(valid_top), 32'd0);
    chk_img("mrst_img", img_source, '0);
    chk("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("mrst_pix_ready", 32'(pix_ready), 32'd1);
    ready_top = 1'b1;
    send_frame(2, 77, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Saturation: one pixel, then 300 sof beats
    send_pix(8'h01, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      send_pix(8'(i), 1'b1);
      if (i == 100) chk("sat_100", 32'(drop_cnt), 32'd100);
      if (i == 255) chk("sat_255", 32'(drop_cnt), 32'd255);
    end
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    chk("sat_no_frame", 32'(valid_top), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
